// File: rtl/axis_frame_gen_if.sv
// AXI-Stream bundle for the frame generator: payload, byte keep, last marker
// and the valid/ready handshake.
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// Command-driven AXI-Stream frame generator: emits cmd_len bytes of an
// incrementing 0..255 pattern, then strobes a completion status.
module axis_frame_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  axis_frame_gen_if.master     m_axis,
  output logic [LEN_WIDTH-1:0] done_len,
  output logic                 done_valid,
  output logic                 done_err
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [LEN_WIDTH-1:0] KW_LEN  = LEN_WIDTH'(KEEP_WIDTH);
  localparam logic [7:0]           KW_BYTE = 8'(KEEP_WIDTH);

  state_t                 state_reg;
  logic                   cmd_ready_reg;
  logic                   tvalid_reg;
  logic                   tlast_reg;
  logic [DATA_WIDTH-1:0]  tdata_reg;
  logic                   done_valid_reg;
  logic                   done_err_reg;
  logic [LEN_WIDTH-1:0]   done_len_reg;
  logic [LEN_WIDTH-1:0]   len_reg;
  logic [LEN_WIDTH-1:0]   rem_reg;
  logic [7:0]             base_reg;

  logic [7:0]             base_next;
  logic [LEN_WIDTH-1:0]   rem_next;
  logic [DATA_WIDTH-1:0]  data_next;
  logic [KEEP_WIDTH-1:0]  keep_next;
  logic                   last_next;
  logic                   accept;
  logic                   transfer;
  logic                   load_beat;

  assign accept    = (state_reg == IDLE) && cmd_valid && cmd_ready_reg;
  assign transfer  = tvalid_reg && m_axis.tready;
  assign load_beat = (accept && (cmd_len != '0)) ||
                     ((state_reg == SEND) && transfer && !tlast_reg);

  // rem counts bytes still owed including the beat being built, so it only
  // ever decreases and the full-scale length cannot overflow.
  always_comb begin
    base_next = 8'd0;
    rem_next  = cmd_len;
    if (state_reg == SEND) begin
      base_next = base_reg + KW_BYTE;
      rem_next  = rem_reg - KW_LEN;
    end
    last_next = (rem_next <= KW_LEN);
  end

  for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
    assign keep_next[gi]          = (LEN_WIDTH'(gi) < rem_next);
    assign data_next[gi*8 +: 8]   = keep_next[gi] ? (base_next + 8'(gi)) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cmd_ready_reg  <= 1'b0;
      tvalid_reg     <= 1'b0;
      tlast_reg      <= 1'b0;
      tdata_reg      <= '0;
      done_valid_reg <= 1'b0;
      done_err_reg   <= 1'b0;
      done_len_reg   <= '0;
      len_reg        <= '0;
      rem_reg        <= '0;
      base_reg       <= 8'd0;
    end else begin
      done_valid_reg <= 1'b0;
      done_err_reg   <= 1'b0;
      if (load_beat) begin
        tdata_reg <= data_next;
        tlast_reg <= last_next;
        rem_reg   <= rem_next;
        base_reg  <= base_next;
      end
      case (state_reg)
        IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (accept) begin
            if (cmd_len == '0) begin
              done_valid_reg <= 1'b1;
              done_err_reg   <= 1'b1;
              done_len_reg   <= '0;
            end else begin
              state_reg     <= SEND;
              cmd_ready_reg <= 1'b0;
              tvalid_reg    <= 1'b1;
              len_reg       <= cmd_len;
            end
          end
        end
        SEND: begin
          if (transfer && tlast_reg) begin
            state_reg      <= IDLE;
            cmd_ready_reg  <= 1'b1;
            tvalid_reg     <= 1'b0;
            tlast_reg      <= 1'b0;
            done_valid_reg <= 1'b1;
            done_len_reg   <= len_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  if (KEEP_ENABLE) begin : g_keep
    logic [KEEP_WIDTH-1:0] tkeep_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tkeep_reg <= '0;
      end else if (load_beat) begin
        tkeep_reg <= keep_next;
      end
    end
    assign m_axis.tkeep = tkeep_reg;
  end else begin : g_nokeep
    assign m_axis.tkeep = '1;
  end

  assign cmd_ready     = cmd_ready_reg;
  assign m_axis.tvalid = tvalid_reg;
  assign m_axis.tlast  = tlast_reg;
  assign m_axis.tdata  = tdata_reg;
  assign done_valid    = done_valid_reg;
  assign done_err      = done_err_reg;
  assign done_len      = done_len_reg;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench: an 8-bit (keep tied) and a 32-bit (keep generated)
// generator share clock and reset; expected beats/status are queued per command.
module tb_axis_frame_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] cmd_len8 = '0, cmd_len32 = '0;
  logic        cmd_valid8 = 1'b0, cmd_valid32 = 1'b0;
  logic        cmd_ready8, cmd_ready32;
  logic [15:0] done_len8, done_len32;
  logic        done_valid8, done_valid32, done_err8, done_err32;
  logic        rdy8 = 1'b1, rdy32 = 1'b1;
  logic        rand_on = 1'b0;

  axis_frame_gen_if #(.DATA_WIDTH(8))  ax8 ();
  axis_frame_gen_if #(.DATA_WIDTH(32)) ax32 ();
  assign ax8.tready  = rdy8;
  assign ax32.tready = rdy32;

  axis_frame_gen #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .cmd_len(cmd_len8), .cmd_valid(cmd_valid8),
    .cmd_ready(cmd_ready8), .m_axis(ax8), .done_len(done_len8),
    .done_valid(done_valid8), .done_err(done_err8)
  );

  axis_frame_gen #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .cmd_len(cmd_len32), .cmd_valid(cmd_valid32),
    .cmd_ready(cmd_ready32), .m_axis(ax32), .done_len(done_len32),
    .done_valid(done_valid32), .done_err(done_err32)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t       q8[$], q32[$];
  logic [16:0] dq8[$], dq32[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        hold_v[2];
  beat_t       hold_b[2];
  logic        prev_last[2];
  logic [15:0] last_done[2];
  int          beats_seen[2];
  int          stall_cnt[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      hold_v[d] = 1'b0;
      prev_last[d] = 1'b0;
      last_done[d] = '0;
    end
  endtask

  task automatic push_frame(input int d, input int len);
    int    kw, nb, k;
    beat_t bt;
    logic [31:0] kv;
    kw = (d != 0) ? 4 : 1;
    nb = (len + kw - 1) / kw;
    for (int b = 0; b < nb; b++) begin
      bt = '0;
      for (int j = 0; j < kw; j++) begin
        k = b * kw + j;
        if (k < len) begin
          kv = k;
          bt.data[j*8 +: 8] = kv[7:0];
          bt.keep[j] = 1'b1;
        end
      end
      bt.last = (b == nb - 1);
      if (d != 0) q32.push_back(bt); else q8.push_back(bt);
    end
    if (d != 0) dq32.push_back({len == 0, 16'(len)});
    else        dq8.push_back({len == 0, 16'(len)});
  endtask

  task automatic mon(input int d, input logic tv, input logic tr, input logic tl,
                     input logic [31:0] td, input logic [3:0] tk, input logic cr,
                     input logic dv, input logic de, input logic [15:0] dl);
    beat_t cur, ex;
    logic [16:0] dx;
    logic empty;
    cur = {td, tk, tl};
    if (prev_last[d]) check($sformatf("gap_tvalid%0d", d), tv, 1'b0);
    if (hold_v[d]) begin
      check($sformatf("stall_tvalid%0d", d), tv, 1'b1);
      if (tv) check($sformatf("stall_hold%0d", d), cur, hold_b[d]);
    end
    hold_v[d] = tv && !tr;
    hold_b[d] = cur;
    if (tv && !tr) stall_cnt[d]++;
    if (tv) check($sformatf("cmd_ready_send%0d", d), cr, 1'b0);
    prev_last[d] = tv && tr && tl;
    if (tv && tr) begin
      empty = (d != 0) ? (q32.size() == 0) : (q8.size() == 0);
      if (empty) check($sformatf("unexpected_beat%0d", d), 1'b1, 1'b0);
      else begin
        ex = (d != 0) ? q32.pop_front() : q8.pop_front();
        check($sformatf("tdata%0d", d), td, ex.data);
        check($sformatf("tkeep%0d", d), tk, ex.keep);
        check($sformatf("tlast%0d", d), tl, ex.last);
      end
      beats_seen[d]++;
    end
    if (dv) begin
      empty = (d != 0) ? (dq32.size() == 0) : (dq8.size() == 0);
      if (empty) check($sformatf("unexpected_done%0d", d), 1'b1, 1'b0);
      else begin
        dx = (d != 0) ? dq32.pop_front() : dq8.pop_front();
        check($sformatf("done_len%0d", d), dl, dx[15:0]);
        check($sformatf("done_err%0d", d), de, dx[16]);
        last_done[d] = dx[15:0];
        $display("done%0d: len=%0d err=%0b", d, dl, de);
      end
    end else begin
      check($sformatf("done_err_idle%0d", d), de, 1'b0);
      check($sformatf("done_len_hold%0d", d), dl, last_done[d]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ax8.tvalid, ax8.tready, ax8.tlast, {24'd0, ax8.tdata}, {3'd0, ax8.tkeep},
          cmd_ready8, done_valid8, done_err8, done_len8);
      mon(1, ax32.tvalid, ax32.tready, ax32.tlast, ax32.tdata, ax32.tkeep,
          cmd_ready32, done_valid32, done_err32, done_len32);
    end
  end

  task automatic send_cmd(input int d, input int len);
    bit ok;
    push_frame(d, len);
    @(posedge clk); #1;
    if (d != 0) begin cmd_valid32 = 1'b1; cmd_len32 = 16'(len); end
    else        begin cmd_valid8  = 1'b1; cmd_len8  = 16'(len); end
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      ok = (d != 0) ? cmd_ready32 : cmd_ready8;
    end
    if (!ok) check($sformatf("cmd_accept_timeout%0d", d), 1'b0, 1'b1);
    @(posedge clk); #1;
    if (d != 0) cmd_valid32 = 1'b0; else cmd_valid8 = 1'b0;
    $display("cmd%0d: len=%0d accepted", d, len);
    if (len != 0) check($sformatf("first_beat_latency%0d", d),
                        (d != 0) ? ax32.tvalid : ax8.tvalid, 1'b1);
    else          check($sformatf("zero_len_no_beat%0d", d),
                        (d != 0) ? ax32.tvalid : ax8.tvalid, 1'b0);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30000 && !ok; i++) begin
      @(negedge clk);
      ok = (q8.size() == 0) && (q32.size() == 0) && (dq8.size() == 0) && (dq32.size() == 0);
    end
    if (!ok) check("drain_timeout", 1'b0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs;
    bit ok;
    clear_mon();
    for (int d = 0; d < 2; d++) begin beats_seen[d] = 0; stall_cnt[d] = 0; end

    #12;
    check("rst_cmd_ready8", cmd_ready8, 1'b0);
    check("rst_tvalid8", ax8.tvalid, 1'b0);
    check("rst_tlast8", ax8.tlast, 1'b0);
    check("rst_tdata8", ax8.tdata, 8'd0);
    check("rst_tkeep8_tied", ax8.tkeep, 1'b1);
    check("rst_cmd_ready32", cmd_ready32, 1'b0);
    check("rst_tvalid32", ax32.tvalid, 1'b0);
    check("rst_tdata32", ax32.tdata, 32'd0);
    check("rst_tkeep32", ax32.tkeep, 4'd0);
    check("rst_done32", {done_valid32, done_err32, done_len32}, 18'd0);
    check("rst_done8", {done_valid8, done_err8, done_len8}, 18'd0);
    #11 rst_n = 1'b1;
    #1 check("ready_before_edge", cmd_ready8, 1'b0);
    @(posedge clk); #1;
    check("ready_after_edge8", cmd_ready8, 1'b1);
    check("ready_after_edge32", cmd_ready32, 1'b1);

    send_cmd(0, 3);
    wait_drain();
    send_cmd(1, 6);
    wait_drain();

    stall_cnt[0] = 0;
    rdy8 = 1'b0;
    send_cmd(0, 2);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rdy8 = 1'b1;
    wait_drain();
    check("stall_cycles", stall_cnt[0], 3);

    send_cmd(0, 0);
    send_cmd(1, 0);
    wait_drain();

    send_cmd(0, 300);
    wait_drain();

    send_cmd(0, 1);
    send_cmd(0, 2);
    send_cmd(0, 5);
    wait_drain();

    rand_on = 1'b1;
    fork
      begin
        for (int n = 1; n <= 9; n++) send_cmd(1, n);
        send_cmd(1, 0);
        send_cmd(1, 13);
        wait_drain();
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          rdy32 = 1'($urandom_range(0, 1));
        end
      end
    join
    rdy32 = 1'b1;

    send_cmd(1, 65535);
    wait_drain();

    bs = beats_seen[0];
    send_cmd(0, 5);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (beats_seen[0] >= bs + 2);
    end
    if (!ok) check("midframe_timeout", 1'b0, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_tvalid", ax8.tvalid, 1'b0);
    check("async_tlast", ax8.tlast, 1'b0);
    check("async_tdata", ax8.tdata, 8'd0);
    check("async_cmd_ready", cmd_ready8, 1'b0);
    check("async_done", {done_valid8, done_err8, done_len8}, 18'd0);
    q8.delete();
    dq8.delete();
    clear_mon();
    #3 rst_n = 1'b1;
    @(posedge clk); #1 check("ready_after_reset", cmd_ready8, 1'b1);
    send_cmd(0, 1);
    wait_drain();

    check("beat_queues_empty", q8.size() + q32.size(), 0);
    check("done_queues_empty", dq8.size() + dq32.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
